// File: rtl/decode_stage_if.sv
// ID/EX output bundle from the decode stage to execute.
interface decode_stage_if;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_rs1_data;
  logic [31:0] id_rs2_data;
  logic [31:0] id_imm;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic [4:0]  id_rd;
  logic [6:0]  id_opcode;
  logic [2:0]  id_funct3;
  logic [6:0]  id_funct7;
  logic        id_mem_read;

  modport master (output id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm, id_rs1, id_rs2,
                         id_rd, id_opcode, id_funct3, id_funct7, id_mem_read);
  modport slave  (input  id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm, id_rs1, id_rs2,
                         id_rd, id_opcode, id_funct3, id_funct7, id_mem_read);
endinterface

// File: rtl/decode_stage.sv
// RV32 decode stage: IF/ID register, load-use hazard detection, bypassed register file,
// immediate generation and ID/EX register.
module decode_stage #(
  parameter logic [31:0] NOP_INST = 32'h00000013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] PC,
  input  logic [31:0] instruction,
  input  logic        branch,
  input  logic        ex_mem_read,
  input  logic [4:0]  ex_rd,
  input  logic        wb_en,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  output logic        PCWrite,
  decode_stage_if.master id_o
);
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        mem_read;
  } idex_t;

  logic [31:0] ifid_pc_q, ifid_pc_d;
  logic [31:0] ifid_inst_q, ifid_inst_d;
  logic        ifid_valid_q, ifid_valid_d;
  logic [31:0] rf_q [32];
  logic [31:0] rf_d [32];
  idex_t       idex_q, idex_d;

  logic [6:0]  opcode;
  logic [4:0]  rs1, rs2, rd;
  logic        rs2_used, stall, bubble;
  logic [31:0] rs1_data, rs2_data, imm;

  assign opcode   = ifid_inst_q[6:0];
  assign rd       = ifid_inst_q[11:7];
  assign rs1      = ifid_inst_q[19:15];
  assign rs2      = ifid_inst_q[24:20];
  assign rs2_used = (opcode == OP_REG) || (opcode == OP_STORE) || (opcode == OP_BRANCH);
  assign stall    = ifid_valid_q && ex_mem_read && (ex_rd != 5'd0) &&
                    ((ex_rd == rs1) || (rs2_used && (ex_rd == rs2)));
  assign PCWrite  = rst_n & ~stall;
  assign bubble   = branch | stall | ~ifid_valid_q;

  // Reads see the write-back value in the same cycle it is written.
  assign rs1_data = (rs1 == 5'd0) ? 32'd0 : (wb_en && wb_rd == rs1) ? wb_data : rf_q[rs1];
  assign rs2_data = (rs2 == 5'd0) ? 32'd0 : (wb_en && wb_rd == rs2) ? wb_data : rf_q[rs2];

  always_comb begin
    imm = 32'd0;
    case (opcode)
      OP_LOAD, OP_IMM, OP_JALR: imm = {{20{ifid_inst_q[31]}}, ifid_inst_q[31:20]};
      OP_STORE:  imm = {{20{ifid_inst_q[31]}}, ifid_inst_q[31:25], ifid_inst_q[11:7]};
      OP_BRANCH: imm = {{20{ifid_inst_q[31]}}, ifid_inst_q[7], ifid_inst_q[30:25],
                        ifid_inst_q[11:8], 1'b0};
      OP_LUI, OP_AUIPC: imm = {ifid_inst_q[31:12], 12'd0};
      OP_JAL:    imm = {{12{ifid_inst_q[31]}}, ifid_inst_q[19:12], ifid_inst_q[20],
                        ifid_inst_q[30:21], 1'b0};
      default:   imm = 32'd0;
    endcase
  end

  always_comb begin
    ifid_pc_d    = PC;
    ifid_inst_d  = instruction;
    ifid_valid_d = 1'b1;
    if (branch) begin
      ifid_pc_d    = 32'd0;
      ifid_inst_d  = NOP_INST;
      ifid_valid_d = 1'b0;
    end else if (stall) begin
      ifid_pc_d    = ifid_pc_q;
      ifid_inst_d  = ifid_inst_q;
      ifid_valid_d = ifid_valid_q;
    end
  end

  always_comb begin
    rf_d = rf_q;
    if (wb_en && wb_rd != 5'd0) rf_d[wb_rd] = wb_data;
  end

  always_comb begin
    idex_d = '0;
    if (!bubble) begin
      idex_d.valid    = 1'b1;
      idex_d.pc       = ifid_pc_q;
      idex_d.rs1_data = rs1_data;
      idex_d.rs2_data = rs2_data;
      idex_d.imm      = imm;
      idex_d.rs1      = rs1;
      idex_d.rs2      = rs2;
      idex_d.rd       = rd;
      idex_d.opcode   = opcode;
      idex_d.funct3   = ifid_inst_q[14:12];
      idex_d.funct7   = ifid_inst_q[31:25];
      idex_d.mem_read = (opcode == OP_LOAD);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ifid_pc_q    <= 32'd0;
      ifid_inst_q  <= NOP_INST;
      ifid_valid_q <= 1'b0;
      idex_q       <= '0;
      for (int i = 0; i < 32; i++) rf_q[i] <= 32'd0;
    end else begin
      ifid_pc_q    <= ifid_pc_d;
      ifid_inst_q  <= ifid_inst_d;
      ifid_valid_q <= ifid_valid_d;
      idex_q       <= idex_d;
      rf_q         <= rf_d;
    end
  end

  assign id_o.id_valid    = idex_q.valid;
  assign id_o.id_pc       = idex_q.pc;
  assign id_o.id_rs1_data = idex_q.rs1_data;
  assign id_o.id_rs2_data = idex_q.rs2_data;
  assign id_o.id_imm      = idex_q.imm;
  assign id_o.id_rs1      = idex_q.rs1;
  assign id_o.id_rs2      = idex_q.rs2;
  assign id_o.id_rd       = idex_q.rd;
  assign id_o.id_opcode   = idex_q.opcode;
  assign id_o.id_funct3   = idex_q.funct3;
  assign id_o.id_funct7   = idex_q.funct7;
  assign id_o.id_mem_read = idex_q.mem_read;
endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: reset, decode, load-use, flush, bypass/x0, immediates.
module tb_decode_stage;
  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] PC, instruction;
  logic        branch, ex_mem_read, wb_en, PCWrite;
  logic [4:0]  ex_rd, wb_rd;
  logic [31:0] wb_data;
  int          n_tests = 0;
  int          n_fail  = 0;

  decode_stage_if id_if ();

  decode_stage #(.NOP_INST(NOP)) dut (
    .clk(clk), .rst_n(rst_n), .PC(PC), .instruction(instruction), .branch(branch),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .wb_en(wb_en), .wb_rd(wb_rd),
    .wb_data(wb_data), .PCWrite(PCWrite), .id_o(id_if.master)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; PC = 32'd0; instruction = NOP; branch = 1'b0;
    ex_mem_read = 1'b0; ex_rd = 5'd0; wb_en = 1'b0; wb_rd = 5'd0; wb_data = 32'd0;
    tick(); tick();
    n_tests++;
    if (id_if.id_valid !== 1'b0 || id_if.id_pc !== 32'd0 || id_if.id_rd !== 5'd0 ||
        id_if.id_imm !== 32'd0 || id_if.id_rs1_data !== 32'd0 || id_if.id_mem_read !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idex: valid=%b pc=%h rd=%0d imm=%h expected all zero",
               id_if.id_valid, id_if.id_pc, id_if.id_rd, id_if.id_imm);
    end
    n_tests++;
    if (PCWrite !== 1'b0) begin n_fail++; $display("FAIL reset_pcwrite_low: got %b expected 0", PCWrite); end
    n_tests++;
    if (dut.ifid_inst_q !== NOP || dut.ifid_valid_q !== 1'b0) begin
      n_fail++; $display("FAIL reset_ifid: inst=%h valid=%b expected %h 0", dut.ifid_inst_q, dut.ifid_valid_q, NOP);
    end
    rst_n = 1'b1; #1;
    n_tests++;
    if (PCWrite !== 1'b1) begin n_fail++; $display("FAIL reset_release_pcwrite: got %b expected 1", PCWrite); end
  endtask

  task automatic test_decode();
    wb_en = 1'b1; wb_rd = 5'd5; wb_data = 32'h1234;
    tick();
    wb_en = 1'b0; PC = 32'h8; instruction = 32'h00528313;
    tick();
    instruction = NOP; PC = 32'hC;
    tick();
    n_tests++;
    if (id_if.id_valid !== 1'b1 || id_if.id_pc !== 32'h8 || id_if.id_rs1 !== 5'd5 ||
        id_if.id_rs1_data !== 32'h1234 || id_if.id_imm !== 32'd5 || id_if.id_rd !== 5'd6) begin
      n_fail++;
      $display("FAIL decode_addi: valid=%b pc=%h rs1=%0d rs1d=%h imm=%h rd=%0d expected 1 8 5 1234 5 6",
               id_if.id_valid, id_if.id_pc, id_if.id_rs1, id_if.id_rs1_data, id_if.id_imm, id_if.id_rd);
    end
    n_tests++;
    if (id_if.id_opcode !== 7'h13 || id_if.id_mem_read !== 1'b0 || id_if.id_funct3 !== 3'd0) begin
      n_fail++; $display("FAIL decode_fields: opcode=%h mr=%b expected 13 0", id_if.id_opcode, id_if.id_mem_read);
    end
  endtask

  task automatic test_load_use();
    PC = 32'hC; instruction = 32'h001303B3;  // add x7,x6,x1
    tick();
    ex_mem_read = 1'b1; ex_rd = 5'd6; PC = 32'h10; instruction = 32'h00100093;
    #1;
    n_tests++;
    if (PCWrite !== 1'b0) begin n_fail++; $display("FAIL loaduse_pcwrite: got %b expected 0", PCWrite); end
    tick();
    n_tests++;
    if (dut.ifid_inst_q !== 32'h001303B3 || dut.ifid_pc_q !== 32'hC) begin
      n_fail++; $display("FAIL loaduse_ifid_hold: inst=%h pc=%h expected 001303b3 c", dut.ifid_inst_q, dut.ifid_pc_q);
    end
    n_tests++;
    if (id_if.id_valid !== 1'b0 || id_if.id_rd !== 5'd0 || id_if.id_opcode !== 7'd0) begin
      n_fail++; $display("FAIL loaduse_bubble: valid=%b rd=%0d op=%h expected 0 0 0", id_if.id_valid, id_if.id_rd, id_if.id_opcode);
    end
    ex_mem_read = 1'b0; ex_rd = 5'd0; #1;
    n_tests++;
    if (PCWrite !== 1'b1) begin n_fail++; $display("FAIL loaduse_clear: got %b expected 1", PCWrite); end
    tick();
    n_tests++;
    if (id_if.id_valid !== 1'b1 || id_if.id_rd !== 5'd7 || id_if.id_rs1 !== 5'd6 || id_if.id_rs2 !== 5'd1 ||
        dut.ifid_inst_q !== 32'h00100093) begin
      n_fail++; $display("FAIL loaduse_resume: valid=%b rd=%0d rs1=%0d rs2=%0d ifid=%h expected 1 7 6 1 00100093",
                         id_if.id_valid, id_if.id_rd, id_if.id_rs1, id_if.id_rs2, dut.ifid_inst_q);
    end
  endtask

  task automatic test_flush();
    PC = 32'h14; instruction = 32'h001303B3;
    tick();
    ex_mem_read = 1'b1; ex_rd = 5'd1; #1;  // rs2 of an R-type
    n_tests++;
    if (PCWrite !== 1'b0) begin n_fail++; $display("FAIL flush_stall_rs2: got %b expected 0", PCWrite); end
    branch = 1'b1;
    tick();
    branch = 1'b0; #1;
    n_tests++;
    if (dut.ifid_inst_q !== NOP || dut.ifid_valid_q !== 1'b0) begin
      n_fail++; $display("FAIL flush_ifid: inst=%h valid=%b expected %h 0", dut.ifid_inst_q, dut.ifid_valid_q, NOP);
    end
    n_tests++;
    if (id_if.id_valid !== 1'b0 || id_if.id_pc !== 32'd0) begin
      n_fail++; $display("FAIL flush_bubble: valid=%b pc=%h expected 0 0", id_if.id_valid, id_if.id_pc);
    end
    n_tests++;
    if (PCWrite !== 1'b1) begin n_fail++; $display("FAIL flush_pcwrite: got %b expected 1", PCWrite); end
    ex_mem_read = 1'b0; ex_rd = 5'd0;
  endtask

  task automatic test_bypass_x0();
    instruction = 32'h00300433;  // add x8,x0,x3
    tick();
    wb_en = 1'b1; wb_rd = 5'd3; wb_data = 32'hDEAD; instruction = 32'h000004B3;  // add x9,x0,x0
    tick();
    n_tests++;
    if (id_if.id_rs2_data !== 32'hDEAD || id_if.id_rs1_data !== 32'd0) begin
      n_fail++; $display("FAIL bypass_rs2: rs2d=%h rs1d=%h expected dead 0", id_if.id_rs2_data, id_if.id_rs1_data);
    end
    wb_rd = 5'd0; wb_data = 32'hBEEF; instruction = 32'h00018533;  // add x10,x3,x0
    tick();
    n_tests++;
    if (id_if.id_rs1_data !== 32'd0 || id_if.id_rs2_data !== 32'd0) begin
      n_fail++; $display("FAIL x0_during_write: rs1d=%h rs2d=%h expected 0 0", id_if.id_rs1_data, id_if.id_rs2_data);
    end
    wb_en = 1'b0; instruction = NOP;
    tick();
    n_tests++;
    if (id_if.id_rs1_data !== 32'hDEAD || id_if.id_rs2_data !== 32'd0) begin
      n_fail++; $display("FAIL x3_stored_x0_zero: rs1d=%h rs2d=%h expected dead 0", id_if.id_rs1_data, id_if.id_rs2_data);
    end
  endtask

  task automatic test_imm();
    logic [31:0] insts [7] = '{32'hFE000EE3, 32'hFFFFF0B7, 32'h0080006F, 32'hFE20AC23,
                               32'h0040A283, 32'h0000000B, 32'hFFF00093};
    logic [31:0] imms  [7] = '{32'hFFFFFFFC, 32'hFFFFF000, 32'h00000008, 32'hFFFFFFF8,
                               32'h00000004, 32'h00000000, 32'hFFFFFFFF};
    logic        mrs   [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 7; i++) begin
      instruction = insts[i];
      tick(); tick();
      n_tests++;
      if (id_if.id_imm !== imms[i] || id_if.id_mem_read !== mrs[i] || id_if.id_valid !== 1'b1) begin
        n_fail++; $display("FAIL imm_%0d: inst=%h imm=%h mr=%b expected imm=%h mr=%b",
                           i, insts[i], id_if.id_imm, id_if.id_mem_read, imms[i], mrs[i]);
      end
    end
  endtask

  task automatic test_reset_override();
    instruction = 32'h001303B3;
    tick();
    ex_mem_read = 1'b1; ex_rd = 5'd6; branch = 1'b1; rst_n = 1'b0;
    tick();
    n_tests++;
    if (dut.ifid_inst_q !== NOP || dut.ifid_valid_q !== 1'b0 || dut.ifid_pc_q !== 32'd0 ||
        id_if.id_valid !== 1'b0 || PCWrite !== 1'b0) begin
      n_fail++; $display("FAIL reset_override: ifid=%h v=%b idv=%b pcw=%b expected %h 0 0 0",
                         dut.ifid_inst_q, dut.ifid_valid_q, id_if.id_valid, PCWrite, NOP);
    end
    ex_mem_read = 1'b0; ex_rd = 5'd0; branch = 1'b0; rst_n = 1'b1;
    instruction = 32'h00018533;  // add x10,x3,x0 -- x3 must be cleared
    tick(); tick();
    n_tests++;
    if (id_if.id_valid !== 1'b1 || id_if.id_rs1_data !== 32'd0) begin
      n_fail++; $display("FAIL reset_clears_rf: valid=%b rs1d=%h expected 1 0", id_if.id_valid, id_if.id_rs1_data);
    end
  endtask

  initial begin
    test_reset();
    test_decode();
    test_load_use();
    test_flush();
    test_bypass_x0();
    test_imm();
    test_reset_override();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
